// File: rtl/scan_display_drv.sv
`default_nettype none
// ============================================================================
//  Module   : scan_display_drv
//  Purpose  : Multiplexed seven-segment driver for DIGITS common-cathode or
//             common-anode digits. It provides a scan prescaler, per-digit hex
//             decode, a double-buffered data load that commits on frame
//             boundaries, leading-zero blanking, decimal points and a
//             whole-display blink.
//  Ports    : Clk        - system clock; all logic uses the rising edge
//             Aclr       - synchronous active-high reset
//             load       - one-cycle strobe that captures data_in / dp_in
//             data_in    - hex nibbles; nibble i drives digit i
//             dp_in      - decimal-point enables; bit i drives digit i
//             blank_lz   - enables leading-zero blanking
//             blink_en   - enables blinking of the whole display
//             busy       - a load is pending and has not been committed yet
//             com        - digit select; polarity set by COM_ACTIVE_LOW
//             seg        - segments {a,b,c,d,e,f,g}; 1 = lit
//             dp         - decimal point; 1 = lit
//             frame_tick - one-cycle pulse after each full scan frame
//  Revision : 1.0 - initial release
// ============================================================================
module scan_display_drv #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 4,
    parameter int BLINK_FRAMES   = 8,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Aclr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic                  busy,
    output logic [DIGITS-1:0]     com,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int c_IDX_W  = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int c_PCNT_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int c_BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(SCAN_DIV - 1);
    localparam logic [c_BLK_W-1:0]  c_BLK_LAST  = c_BLK_W'(BLINK_FRAMES - 1);
    localparam logic [DIGITS-1:0]   c_COM_OFF   = {DIGITS{COM_ACTIVE_LOW}};

    logic [c_PCNT_W-1:0] r_pcnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_BLK_W-1:0]  r_bcnt;
    logic                r_bphase;
    logic [4*DIGITS-1:0] r_pend_data;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_busy;
    logic [4*DIGITS-1:0] r_disp_data;
    logic [DIGITS-1:0]   r_disp_dp;
    logic [DIGITS-1:0]   r_com;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_frame_tick;

    logic                w_digit_tick;
    logic                w_frame_end;
    logic [DIGITS-1:0]   w_zero_above;
    logic [DIGITS-1:0]   w_sel;
    logic [DIGITS-1:0]   w_com_on;
    logic [3:0]          w_nib;
    logic                w_dp_bit;
    logic                w_upper_zero;
    logic                w_blank;
    logic                w_dark;
    logic [6:0]          w_hex;

    assign w_digit_tick = (r_pcnt == c_PCNT_LAST);
    assign w_frame_end  = w_digit_tick && (r_idx == c_IDX_LAST);

    // w_zero_above[i]: this digit and every more significant one hold zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero_above
        assign w_zero_above[gi] = (r_disp_data[4*DIGITS-1:4*gi] == '0);
    end

    // Pick out everything belonging to the digit currently being scanned.
    always_comb begin
        w_nib        = 4'h0;
        w_dp_bit     = 1'b0;
        w_upper_zero = 1'b0;
        w_sel        = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nib        = r_disp_data[4*i +: 4];
                w_dp_bit     = r_disp_dp[i];
                w_upper_zero = w_zero_above[i];
                w_sel[i]     = 1'b1;
            end
        end
    end

    assign w_com_on = COM_ACTIVE_LOW ? ~w_sel : w_sel;
    // Digit 0 is never blanked so that a value of zero still shows "0".
    assign w_blank  = blank_lz && (r_idx != '0) && w_upper_zero;
    assign w_dark   = blink_en && r_bphase;

    always_comb begin
        w_hex = 7'h00;
        case (w_nib)
            4'h0: w_hex = 7'h7E;
            4'h1: w_hex = 7'h30;
            4'h2: w_hex = 7'h6D;
            4'h3: w_hex = 7'h79;
            4'h4: w_hex = 7'h33;
            4'h5: w_hex = 7'h5B;
            4'h6: w_hex = 7'h5F;
            4'h7: w_hex = 7'h70;
            4'h8: w_hex = 7'h7F;
            4'h9: w_hex = 7'h7B;
            4'hA: w_hex = 7'h77;
            4'hB: w_hex = 7'h1F;
            4'hC: w_hex = 7'h4E;
            4'hD: w_hex = 7'h3D;
            4'hE: w_hex = 7'h4F;
            4'hF: w_hex = 7'h47;
            default: w_hex = 7'h00;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Aclr) begin
            r_pcnt       <= '0;
            r_idx        <= '0;
            r_bcnt       <= '0;
            r_bphase     <= 1'b0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_busy       <= 1'b0;
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_com        <= c_COM_OFF;
            r_seg        <= 7'h00;
            r_dp         <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_pcnt <= w_digit_tick ? '0 : r_pcnt + 1'b1;

            if (w_digit_tick) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end

            if (w_frame_end) begin
                if (r_bcnt == c_BLK_LAST) begin
                    r_bcnt   <= '0;
                    r_bphase <= ~r_bphase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end

            // The display register only changes at a frame boundary; a load
            // landing on that boundary is newer than anything pending.
            if (w_frame_end) begin
                if (load) begin
                    r_disp_data <= data_in;
                    r_disp_dp   <= dp_in;
                end else if (r_busy) begin
                    r_disp_data <= r_pend_data;
                    r_disp_dp   <= r_pend_dp;
                end
                r_busy <= 1'b0;
            end else if (load) begin
                r_pend_data <= data_in;
                r_pend_dp   <= dp_in;
                r_busy      <= 1'b1;
            end

            // Segments and dp keep following the scan while blinked dark;
            // only the COM lines are released.
            r_com        <= w_dark ? c_COM_OFF : w_com_on;
            r_seg        <= w_blank ? 7'h00 : w_hex;
            r_dp         <= w_dp_bit;
            r_frame_tick <= w_frame_end;
        end
    end

    assign busy       = r_busy;
    assign com        = r_com;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
